// File: rtl/solver_dispatch.sv
// Host-side driver for one fractal solver core: config push, c-limb load, start, result return.
// Optional build macro SOLVER_DISPATCH_PERF_EN adds res_cycles (WAIT_DONE cycle count per job).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a job; job_ready=1
// CFG       | one cycle pushing shadow num_limbs/iter_lim to the solver
// LOAD_RE   | streaming c-real limbs 0..N-1 into the solver
// LOAD_IM   | streaming c-imag limbs 0..N-1 into the solver
// START     | one-cycle solve start pulse
// WAIT_DONE | waiting for the solver done flag, then capturing the result
// RESULT    | presenting the result until the collector takes it
module solver_dispatch #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_BITS       = 32,
  parameter int TAG_BITS        = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cfg_wr,
  input  logic [LIMB_INDEX_BITS-1:0] cfg_num_limbs,
  input  logic [15:0]                cfg_iter_lim,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [TAG_BITS-1:0]        job_tag,
  input  logic                       limb_valid,
  output logic                       limb_ready,
  input  logic [LIMB_BITS-1:0]       limb_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [TAG_BITS-1:0]        res_tag,
  output logic [15:0]                res_iter,
  output logic                       res_escaped,
`ifdef SOLVER_DISPATCH_PERF_EN
  output logic [31:0]                res_cycles,
`endif
  output logic                       wr_real_en,
  output logic                       wr_imag_en,
  output logic [LIMB_INDEX_BITS-1:0] wr_ind,
  output logic [LIMB_BITS-1:0]       wr_data,
  output logic                       wr_num_limbs_en,
  output logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
  output logic                       wr_iter_lim_en,
  output logic [15:0]                iter_lim_data,
  output logic                       start,
  input  logic                       out_ready,
  input  logic [15:0]                iteration_count
);

  localparam logic [LIMB_INDEX_BITS-1:0] ONE_LIMB      = LIMB_INDEX_BITS'(1);
  localparam logic [15:0]                ITER_LIM_INIT = 16'd255;
  localparam logic [15:0]                ITER_HIT_LIM  = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    LOAD_RE,
    LOAD_IM,
    START,
    WAIT_DONE,
    RESULT
  } state_t;

  state_t state, state_nxt;

  logic [LIMB_INDEX_BITS-1:0] shadow_num_limbs;
  logic [15:0]                shadow_iter_lim;
  logic                       cfg_dirty;
  logic                       cfg_take;
  logic [LIMB_INDEX_BITS-1:0] job_n;
  logic [LIMB_INDEX_BITS-1:0] limb_cnt;
  logic                       limb_last;
  logic [TAG_BITS-1:0]        tag_q;

  // A zero limb count would wedge the load loop, so such writes are dropped outright.
  assign cfg_take  = cfg_wr && (cfg_num_limbs != '0);
  assign limb_last = (limb_cnt == (job_n - ONE_LIMB));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    job_ready       = 1'b0;
    limb_ready      = 1'b0;
    res_valid       = 1'b0;
    wr_real_en      = 1'b0;
    wr_imag_en      = 1'b0;
    wr_ind          = '0;
    wr_data         = '0;
    wr_num_limbs_en = 1'b0;
    num_limbs_data  = '0;
    wr_iter_lim_en  = 1'b0;
    iter_lim_data   = '0;
    start           = 1'b0;
    case (state)
      IDLE: begin
        // Held low while reset is asserted so every output reads 0 during reset.
        job_ready = !reset;
        if (job_valid && !reset) begin
          state_nxt = cfg_dirty ? CFG : LOAD_RE;
        end
      end
      CFG: begin
        wr_num_limbs_en = 1'b1;
        num_limbs_data  = shadow_num_limbs;
        wr_iter_lim_en  = 1'b1;
        iter_lim_data   = shadow_iter_lim;
        state_nxt       = LOAD_RE;
      end
      LOAD_RE: begin
        limb_ready = 1'b1;
        wr_real_en = limb_valid;
        wr_ind     = limb_cnt;
        wr_data    = limb_data;
        if (limb_valid && limb_last) begin
          state_nxt = LOAD_IM;
        end
      end
      LOAD_IM: begin
        limb_ready = 1'b1;
        wr_imag_en = limb_valid;
        wr_ind     = limb_cnt;
        wr_data    = limb_data;
        if (limb_valid && limb_last) begin
          state_nxt = START;
        end
      end
      START: begin
        start     = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (out_ready) begin
          state_nxt = RESULT;
        end
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_num_limbs <= ONE_LIMB;
      shadow_iter_lim  <= ITER_LIM_INIT;
      cfg_dirty        <= 1'b1;
    end else begin
      if (cfg_take) begin
        shadow_num_limbs <= cfg_num_limbs;
        shadow_iter_lim  <= cfg_iter_lim;
        cfg_dirty        <= 1'b1;
      end else if (state == CFG) begin
        cfg_dirty <= 1'b0;
      end
    end
  end

  // job_n survives across jobs so a clean config skips the CFG cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      job_n    <= ONE_LIMB;
      limb_cnt <= '0;
      tag_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (job_valid) begin
            tag_q    <= job_tag;
            limb_cnt <= '0;
          end
        end
        CFG: begin
          job_n <= shadow_num_limbs;
        end
        LOAD_RE, LOAD_IM: begin
          if (limb_valid) begin
            limb_cnt <= limb_last ? '0 : limb_cnt + ONE_LIMB;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res_tag     <= '0;
      res_iter    <= '0;
      res_escaped <= 1'b0;
    end else if (state == WAIT_DONE && out_ready) begin
      res_tag     <= tag_q;
      res_iter    <= iteration_count;
      res_escaped <= (iteration_count != ITER_HIT_LIM);
    end
  end

`ifdef SOLVER_DISPATCH_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_cnt   <= '0;
      res_cycles <= '0;
    end else begin
      if (state == START) begin
        perf_cnt <= '0;
      end else if (state == WAIT_DONE) begin
        if (perf_cnt != 32'hFFFF_FFFF) begin
          perf_cnt <= perf_cnt + 32'd1;
        end
        if (out_ready) begin
          res_cycles <= perf_cnt;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_solver_dispatch.sv
// Self-checking bench for solver_dispatch: behavioural solver model plus write/result scoreboards.
module tb_solver_dispatch;

  localparam int LIB = 6;
  localparam int LB  = 32;
  localparam int TB  = 16;

  logic           clock;
  logic           reset;
  logic           cfg_wr;
  logic [LIB-1:0] cfg_num_limbs;
  logic [15:0]    cfg_iter_lim;
  logic           job_valid;
  logic           job_ready;
  logic [TB-1:0]  job_tag;
  logic           limb_valid;
  logic           limb_ready;
  logic [LB-1:0]  limb_data;
  logic           res_valid;
  logic           res_ready;
  logic [TB-1:0]  res_tag;
  logic [15:0]    res_iter;
  logic           res_escaped;
`ifdef SOLVER_DISPATCH_PERF_EN
  logic [31:0]    res_cycles;
`endif
  logic           wr_real_en;
  logic           wr_imag_en;
  logic [LIB-1:0] wr_ind;
  logic [LB-1:0]  wr_data;
  logic           wr_num_limbs_en;
  logic [LIB-1:0] num_limbs_data;
  logic           wr_iter_lim_en;
  logic [15:0]    iter_lim_data;
  logic           start;
  logic           out_ready;
  logic [15:0]    iteration_count;

  solver_dispatch #(.LIMB_INDEX_BITS(LIB), .LIMB_BITS(LB), .TAG_BITS(TB)) dut (
    .clock(clock), .reset(reset),
    .cfg_wr(cfg_wr), .cfg_num_limbs(cfg_num_limbs), .cfg_iter_lim(cfg_iter_lim),
    .job_valid(job_valid), .job_ready(job_ready), .job_tag(job_tag),
    .limb_valid(limb_valid), .limb_ready(limb_ready), .limb_data(limb_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_iter(res_iter), .res_escaped(res_escaped),
`ifdef SOLVER_DISPATCH_PERF_EN
    .res_cycles(res_cycles),
`endif
    .wr_real_en(wr_real_en), .wr_imag_en(wr_imag_en), .wr_ind(wr_ind), .wr_data(wr_data),
    .wr_num_limbs_en(wr_num_limbs_en), .num_limbs_data(num_limbs_data),
    .wr_iter_lim_en(wr_iter_lim_en), .iter_lim_data(iter_lim_data),
    .start(start), .out_ready(out_ready), .iteration_count(iteration_count)
  );

  typedef struct packed {
    logic [1:0]     kind;   // 0 real limb, 1 imag limb, 2 config push
    logic [LIB-1:0] ind;
    logic [LB-1:0]  data;
  } wr_t;

  typedef struct packed {
    logic [TB-1:0] tag;
    logic [15:0]   iter;
    logic          esc;
  } res_t;

  wr_t  exp_wr[$];
  wr_t  obs_wr[$];
  res_t exp_res[$];

  int compared    = 0;
  int mismatched  = 0;
  int cyc         = 0;
  int start_cyc   = 0;
  int start_cnt   = 0;
  int excl_viol   = 0;
  int bubble_viol = 0;

  int          sol_delay = 1;
  logic [15:0] sol_count = '0;
  int          sol_timer;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  // Solver model: done flag drops the cycle after start, rises sol_delay cycles later.
  always @(posedge clock) begin
    if (reset) begin
      out_ready       <= 1'b1;
      iteration_count <= '0;
      sol_timer       <= 0;
    end else if (start) begin
      out_ready <= 1'b0;
      sol_timer <= sol_delay;
    end else if (!out_ready) begin
      if (sol_timer <= 1) begin
        out_ready       <= 1'b1;
        iteration_count <= sol_count;
      end else begin
        sol_timer <= sol_timer - 1;
      end
    end
  end

  always @(negedge clock) begin
    wr_t w;
    if (wr_real_en) begin
      w = {2'd0, wr_ind, wr_data};
      obs_wr.push_back(w);
    end
    if (wr_imag_en) begin
      w = {2'd1, wr_ind, wr_data};
      obs_wr.push_back(w);
    end
    if (wr_num_limbs_en || wr_iter_lim_en) begin
      w = {2'd2, num_limbs_data, 16'h0, iter_lim_data};
      obs_wr.push_back(w);
    end
    if (wr_num_limbs_en != wr_iter_lim_en) excl_viol++;
    if ($countones({wr_real_en, wr_imag_en, wr_num_limbs_en, start}) > 1) excl_viol++;
    if (job_ready && (limb_ready || res_valid || start)) excl_viol++;
    if ((wr_real_en || wr_imag_en) && !limb_valid) bubble_viol++;
    if (start) begin
      start_cyc = cyc;
      start_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_cfg(input logic [LIB-1:0] n, input logic [15:0] lim);
    cfg_wr        = 1'b1;
    cfg_num_limbs = n;
    cfg_iter_lim  = lim;
    @(posedge clock); #1;
    cfg_wr        = 1'b0;
  endtask

  // Drives one job and its limbs; pushes expected writes and result. Entered and left at posedge+1.
  task automatic drive_job(input logic [TB-1:0] tag, input int n, input logic [LB-1:0] base,
                           input bit bubble, input bit exp_cfg, input logic [LIB-1:0] cfg_n,
                           input logic [15:0] cfg_lim, input int delay, input logic [15:0] count,
                           output int acc);
    wr_t  w;
    res_t r;
    int   idx;
    bit   tog;
    bit   took;
    sol_delay = delay;
    sol_count = count;
    start_cnt = 0;
    if (exp_cfg) begin
      w = {2'd2, cfg_n, 16'h0, cfg_lim};
      exp_wr.push_back(w);
    end
    for (int i = 0; i < n; i++) begin
      w = {2'd0, LIB'(i), base + LB'(i)};
      exp_wr.push_back(w);
    end
    for (int i = 0; i < n; i++) begin
      w = {2'd1, LIB'(i), base + LB'(n + i)};
      exp_wr.push_back(w);
    end
    r = {tag, count, (count != 16'hFFFF)};
    exp_res.push_back(r);
    job_valid = 1'b1;
    job_tag   = tag;
    acc       = -1;
    for (int g = 0; g < 50 && acc < 0; g++) begin
      @(negedge clock);
      if (job_ready) acc = cyc;
      @(posedge clock); #1;
    end
    job_valid = 1'b0;
    if (acc < 0) begin
      compared++;
      mismatched++;
      $display("FAIL job_accept tag=%h: got no job_ready within 50 cycles, need accept", tag);
      return;
    end
    idx = 0;
    tog = 1'b1;
    for (int g = 0; g < 400 && idx < 2 * n; g++) begin
      limb_valid = bubble ? tog : 1'b1;
      limb_data  = base + LB'(idx);
      @(negedge clock);
      took = limb_valid && limb_ready;
      @(posedge clock); #1;
      if (took) idx++;
      tog = !tog;
    end
    limb_valid = 1'b0;
    if (idx < 2 * n) begin
      compared++;
      mismatched++;
      $display("FAIL limb_load tag=%h: got %0d limbs accepted, need %0d", tag, idx, 2 * n);
    end
  endtask

  // Waits for the result, optionally stalls res_ready, then pops and compares. Leaves at posedge+1.
  task automatic collect_result(input int hold);
    res_t cap;
    res_t e;
    bit   got;
    got = 1'b0;
    for (int g = 0; g < 300; g++) begin
      @(negedge clock);
      if (res_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL res_timeout: got res_valid=0 after 300 cycles, need 1");
      @(posedge clock); #1;
      return;
    end
    cap = {res_tag, res_iter, res_escaped};
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      job_valid = 1'b1;
      job_tag   = 16'hDEAD;
      @(negedge clock);
      compared++;
      if ({res_valid, res_tag, res_iter, res_escaped, job_ready} !== {1'b1, cap, 1'b0}) begin
        mismatched++;
        $display("FAIL res_hold cycle %0d: got valid=%b tag=%h iter=%h esc=%b job_ready=%b, need 1 %h %h %b 0",
                 h, res_valid, res_tag, res_iter, res_escaped, job_ready, cap.tag, cap.iter, cap.esc);
      end
    end
    @(posedge clock); #1;
    job_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clock);
    compared++;
    if (exp_res.size() == 0) begin
      mismatched++;
      $display("FAIL res_unexpected: got tag=%h, need no result", res_tag);
    end else begin
      e = exp_res.pop_front();
      if ({res_valid, res_tag, res_iter, res_escaped} !== {1'b1, e.tag, e.iter, e.esc}) begin
        mismatched++;
        $display("FAIL res_fields: got valid=%b tag=%h iter=%h esc=%b, need 1 %h %h %b",
                 res_valid, res_tag, res_iter, res_escaped, e.tag, e.iter, e.esc);
      end
    end
    @(posedge clock); #1;
    res_ready = 1'b0;
    @(negedge clock);
    compared++;
    if (res_valid !== 1'b0 || job_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL res_release: got res_valid=%b job_ready=%b, need 0 1", res_valid, job_ready);
    end
    @(posedge clock); #1;
  endtask

  task automatic score_writes(input string name);
    wr_t o;
    wr_t e;
    compared++;
    if (obs_wr.size() != exp_wr.size()) begin
      mismatched++;
      $display("FAIL %s wr_count: got %0d strobes, need %0d", name, obs_wr.size(), exp_wr.size());
    end
    while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
      o = obs_wr.pop_front();
      e = exp_wr.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL %s wr_entry: got kind=%0d ind=%0d data=%h, need kind=%0d ind=%0d data=%h",
                 name, o.kind, o.ind, o.data, e.kind, e.ind, e.data);
      end
    end
    obs_wr.delete();
    exp_wr.delete();
  endtask

  task automatic check_latency(input string name, input int acc, input int need);
    compared++;
    if (start_cyc - acc !== need || start_cnt !== 1) begin
      mismatched++;
      $display("FAIL %s latency: got %0d cycles (%0d starts), need %0d (1 start)",
               name, start_cyc - acc, start_cnt, need);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    cfg_wr        = 1'b0;
    cfg_num_limbs = '0;
    cfg_iter_lim  = '0;
    job_valid     = 1'b0;
    job_tag       = '0;
    limb_valid    = 1'b0;
    limb_data     = 32'hFFFF_FFFF;
    res_ready     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    compared++;
    if ({job_ready, limb_ready, res_valid, res_tag, res_iter, res_escaped, wr_real_en, wr_imag_en,
         wr_ind, wr_data, wr_num_limbs_en, num_limbs_data, wr_iter_lim_en, iter_lim_data, start} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got job_ready=%b res_valid=%b wr_data=%h start=%b, need all outputs 0",
               job_ready, res_valid, wr_data, start);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    compared++;
    if (job_ready !== 1'b1 || res_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle: got job_ready=%b res_valid=%b, need 1 0", job_ready, res_valid);
    end
    @(posedge clock); #1;
    obs_wr.delete();
  endtask

  task automatic test_default_job();
    int acc;
    drive_job(16'h0042, 1, 32'hA5A5_0000, 1'b0, 1'b1, 6'd1, 16'd255, 10, 16'd7, acc);
    collect_result(0);
    score_writes("default_job");
    check_latency("default_job", acc, 4);
  endtask

  task automatic test_multi_limb();
    int acc;
    pulse_cfg(6'd4, 16'd1000);
    drive_job(16'h1234, 4, 32'd1, 1'b0, 1'b1, 6'd4, 16'd1000, 5, 16'hFFFF, acc);
    collect_result(0);
    score_writes("multi_limb");
    check_latency("multi_limb", acc, 10);
  endtask

  task automatic test_no_cfg();
    int acc;
    drive_job(16'h0777, 4, 32'h100, 1'b0, 1'b0, '0, '0, 3, 16'h0020, acc);
    collect_result(0);
    score_writes("no_cfg");
    check_latency("no_cfg", acc, 9);
  endtask

  task automatic test_res_hold();
    int acc;
    drive_job(16'h0BEE, 4, 32'h200, 1'b0, 1'b0, '0, '0, 2, 16'h0011, acc);
    collect_result(5);
    score_writes("res_hold");
  endtask

  task automatic test_bubbles_cfg();
    int acc;
    pulse_cfg(6'd0, 16'd50);
    drive_job(16'h0C0C, 4, 32'h300, 1'b1, 1'b0, '0, '0, 12, 16'h0040, acc);
    @(posedge clock); #1;
    pulse_cfg(6'd2, 16'd77);
    collect_result(0);
    score_writes("bubbles");
    compared++;
    if (bubble_viol !== 0) begin
      mismatched++;
      $display("FAIL bubble_strobe: got %0d strobes without limb_valid, need 0", bubble_viol);
    end
    drive_job(16'h0D0D, 2, 32'h400, 1'b0, 1'b1, 6'd2, 16'd77, 4, 16'h0003, acc);
    collect_result(0);
    score_writes("late_cfg");
    check_latency("late_cfg", acc, 6);
  endtask

  task automatic test_reset_mid();
    int acc;
    bit got;
    job_valid = 1'b1;
    job_tag   = 16'h0E0E;
    got       = 1'b0;
    for (int g = 0; g < 10 && !got; g++) begin
      @(negedge clock);
      got = job_ready;
      @(posedge clock); #1;
    end
    job_valid  = 1'b0;
    limb_valid = 1'b1;
    limb_data  = 32'h600;
    repeat (2) @(posedge clock);
    #1;
    limb_valid = 1'b0;
    @(negedge clock);
    compared++;
    if (limb_ready !== 1'b1 || wr_imag_en !== 1'b0 || wr_real_en !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_load_im: got limb_ready=%b wr_imag_en=%b wr_real_en=%b, need 1 0 0",
               limb_ready, wr_imag_en, wr_real_en);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    compared++;
    if ({job_ready, limb_ready, res_valid, res_tag, res_iter, res_escaped, wr_real_en, wr_imag_en,
         wr_ind, wr_data, wr_num_limbs_en, num_limbs_data, wr_iter_lim_en, iter_lim_data, start} !== '0) begin
      mismatched++;
      $display("FAIL mid_reset_outputs: got job_ready=%b limb_ready=%b res_valid=%b res_tag=%h, need all 0",
               job_ready, limb_ready, res_valid, res_tag);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    obs_wr.delete();
    drive_job(16'h0F0F, 1, 32'h500, 1'b0, 1'b1, 6'd1, 16'd255, 6, 16'h0009, acc);
    collect_result(0);
    score_writes("after_reset");
    check_latency("after_reset", acc, 4);
  endtask

  task automatic test_exclusive();
    compared++;
    if (excl_viol !== 0) begin
      mismatched++;
      $display("FAIL exclusive: got %0d overlapping strobe/handshake cycles, need 0", excl_viol);
    end
    compared++;
    if (exp_res.size() !== 0) begin
      mismatched++;
      $display("FAIL results_left: got %0d outstanding results, need 0", exp_res.size());
    end
  endtask

  initial begin
    test_reset();
    test_default_job();
    test_multi_limb();
    test_no_cfg();
    test_res_hold();
    test_bubbles_cfg();
    test_reset_mid();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/solver_dispatch.md
Name: solver_dispatch

Overview:
Host-side driver for one fractal solver core; it sits on the other end of the solver's load/start/result interface. It accepts a pixel job (tag plus streamed c limbs), pushes pending configuration, writes the c limbs, pulses start, and waits for completion. It then returns the iteration count to the result collector over a valid/ready handshake. One job is in flight at a time.

Parameters:
LIMB_INDEX_BITS, 6, width of limb index and limb count (matches solver).
LIMB_BITS, 32, width of one c limb word.
TAG_BITS, 16, width of the opaque pixel tag carried from job to result.

Ports:
clock  in  1  clock.
reset  in  1  reset, synchronous, active-high.
cfg_wr  in  1  one-cycle pulse: load the shadow config registers.
cfg_num_limbs  in  LIMB_INDEX_BITS  limbs per coordinate; 0 is illegal.
cfg_iter_lim  in  16  iteration limit.
job_valid  in  1  job request.
job_ready  out  1  job accepted when job_valid && job_ready.
job_tag  in  TAG_BITS  pixel tag.
limb_valid  in  1  limb word valid.
limb_ready  out  1  limb accepted when limb_valid && limb_ready.
limb_data  in  LIMB_BITS  c limb: real limbs 0..N-1, then imag limbs 0..N-1.
res_valid  out  1  result valid.
res_ready  in  1  result consumed when res_valid && res_ready.
res_tag  out  TAG_BITS  tag of the finished job.
res_iter  out  16  solver iteration count; 0xFFFF = hit limit.
res_escaped  out  1  1 iff res_iter != 0xFFFF.
wr_real_en  out  1  solver c-real limb write strobe.
wr_imag_en  out  1  solver c-imag limb write strobe.
wr_ind  out  LIMB_INDEX_BITS  solver limb index.
wr_data  out  LIMB_BITS  limb word to the solver datapath (= limb_data).
wr_num_limbs_en  out  1  solver limb-count write strobe.
num_limbs_data  out  LIMB_INDEX_BITS  limb count to the solver.
wr_iter_lim_en  out  1  solver iteration-limit write strobe.
iter_lim_data  out  16  iteration limit to the solver.
start  out  1  one-cycle solve start.
out_ready  in  1  solver done flag; low from the cycle after start until finish.
iteration_count  in  16  solver result; stable while out_ready=1.

Behaviour:
- Reset values: all outputs 0; shadow num_limbs=1, iter_lim=255; cfg_dirty=1; state IDLE. Reset mid-job abandons the job with no result; the solver is reset by the same reset.
- Config shadow: on cfg_wr with cfg_num_limbs!=0, capture both fields and set cfg_dirty. cfg_wr with cfg_num_limbs==0 is ignored entirely. cfg_wr is accepted in any state; a value written mid-job takes effect from the next job.
- States:
  - IDLE: job_ready=1. On accept, latch job_tag and go to CFG if cfg_dirty, else LOAD_RE; clear the limb counter.
  - CFG: single cycle. Assert wr_num_limbs_en and wr_iter_lim_en with the shadow values, latch the shadow num_limbs as job N, then go to LOAD_RE. Clear cfg_dirty unless cfg_wr arrives in the same cycle.
  - LOAD_RE: limb_ready=1. wr_real_en = limb_valid (combinational), wr_ind = counter, wr_data = limb_data. On each accepted limb the counter increments. On the accepted limb with counter==N-1, the counter goes to 0 and the state to LOAD_IM.
  - LOAD_IM: the same, using wr_imag_en; after the last limb go to START.
  - START: single cycle, start=1, then WAIT_DONE.
  - WAIT_DONE: when out_ready=1, register res_iter=iteration_count, res_tag, and res_escaped, then go to RESULT. out_ready is already low in the first WAIT_DONE cycle, so no masking is needed.
  - RESULT: res_valid=1 with fields held stable. On res_ready go to IDLE; job_ready is 0 that cycle.
- Timing:
  - Latency from job accept to start is 2N+1 cycles, +1 when cfg_dirty and with no limb bubbles.
  - Limb bubbles (limb_valid=0) stall with no strobe.
  - job_ready, limb_ready, and start are never high outside their states.
  - limb_valid in IDLE/WAIT_DONE/RESULT is ignored (limb_ready=0).
- Strobes are mutually exclusive per cycle.

Optional Feature:
SOLVER_DISPATCH_PERF_EN: adds output res_cycles[31:0].
- A counter is cleared in START and incremented each WAIT_DONE cycle, saturating at 0xFFFFFFFF.
- It is latched with res_iter.
- Without the macro the port and counter do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then job tag=0x0042, N default 1: expect CFG strobes with num_limbs=1 and iter_lim=255, one wr_real_en at ind 0, one wr_imag_en at ind 0, start. Model out_ready after 10 cycles with count 7: res_tag=0x0042, res_iter=7, res_escaped=1.
2. cfg_wr N=4, lim=1000; job with limbs re=1..4, im=5..8: wr_ind sequence 0,1,2,3 on each strobe with matching wr_data; count 0xFFFF gives res_escaped=0.
3. Second job without cfg_wr: no CFG cycle; the start cycle is 2N+1 cycles after accept.
4. res_ready held 0 for 5 cycles: res_valid and fields stable, job_ready=0; a new job is accepted only after the res handshake.
5. Toggle limb_valid 1,0,1,...: strobes only on valid cycles, counter does not skip. cfg_wr N=0 is ignored; cfg_wr during WAIT_DONE applies on the next job (CFG present).
6. Assert reset in LOAD_IM: all outputs 0 next cycle; the next job re-sends config (dirty=1).
